// File: rtl/coin_feeder.sv
// coin_feeder: turns a 5-cent-unit payment into paced one-cycle coin codes and reports vend/timeout
module coin_feeder #(
  parameter int GAP_CYCLES  = 1,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] amount,
  input  logic       prefer_dime,
  input  logic       nw_pa,
  output logic [1:0] coin,
  output logic       busy,
  output logic       done,
  output logic       vended,
  output logic       timeout
);
  typedef enum logic [2:0] {IDLE, SEND, GAP, WAIT_ACK, DONE} state_e;
  state_e     state_q, state_d;
  logic [3:0] rem_q, rem_d;
  logic       pref_q, pref_d;
  logic [3:0] gcnt_q, gcnt_d;
  logic [7:0] acnt_q, acnt_d;
  logic [1:0] coin_q, coin_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       vended_q, vended_d;
  logic       timeout_q, timeout_d;
  assign coin    = coin_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign vended  = vended_q;
  assign timeout = timeout_q;
  // coin code doubles as its value in nickels, so it can be subtracted from rem directly
  function automatic logic [1:0] pick(input logic [3:0] r, input logic p);
    return (p && r >= 4'd2) ? 2'b10 : 2'b01;
  endfunction
  // state and registered outputs; outputs are computed for the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      pref_q    <= 1'b0;
      gcnt_q    <= '0;
      acnt_q    <= '0;
      coin_q    <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vended_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      pref_q    <= pref_d;
      gcnt_q    <= gcnt_d;
      acnt_q    <= acnt_d;
      coin_q    <= coin_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      vended_q  <= vended_d;
      timeout_q <= timeout_d;
    end
  end
  // next-state, coin selection, pacing counters and vend/timeout bookkeeping
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    pref_d    = pref_q;
    gcnt_d    = gcnt_q;
    acnt_d    = acnt_q;
    coin_d    = 2'b00;
    vended_d  = vended_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: if (start && amount != 4'd0) begin
        pref_d    = prefer_dime;
        vended_d  = 1'b0;
        timeout_d = 1'b0;
        coin_d    = pick(amount, prefer_dime);
        rem_d     = amount - {2'b00, coin_d};
        state_d   = SEND;
      end
      SEND: begin
        gcnt_d  = '0;
        state_d = GAP;
      end
      GAP: if (gcnt_q == 4'(GAP_CYCLES - 1)) begin
        if (rem_q != 4'd0) begin
          coin_d  = pick(rem_q, pref_q);
          rem_d   = rem_q - {2'b00, coin_d};
          state_d = SEND;
        end else begin
          acnt_d  = '0;
          state_d = WAIT_ACK;
        end
      end else begin
        gcnt_d = gcnt_q + 4'd1;
      end
      WAIT_ACK: if (nw_pa || vended_q) begin
        state_d = DONE;
      end else if (acnt_q == 8'(ACK_TIMEOUT - 1)) begin
        timeout_d = 1'b1;
        state_d   = DONE;
      end else begin
        acnt_d = acnt_q + 8'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // DONE is excluded so a late vend cannot coexist with a reported timeout
    if (nw_pa && (state_q == SEND || state_q == GAP || state_q == WAIT_ACK)) vended_d = 1'b1;
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end
endmodule

// File: tb/tb_coin_feeder.sv
// tb_coin_feeder: directed checks of coin pacing, vend/timeout reporting, ignored starts and reset
module tb_coin_feeder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] amount = 4'd0;
  logic       prefer_dime = 1'b0;
  logic       nw_pa = 1'b0;
  logic [1:0] coin;
  logic       busy, done, vended, timeout;
  int checks = 0;
  int passes = 0;
  int cents = 0;
  logic [1:0] prev_coin = 2'b00;
  logic adj_bad = 1'b0;
  coin_feeder #(.GAP_CYCLES(1), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .amount(amount), .prefer_dime(prefer_dime),
    .nw_pa(nw_pa), .coin(coin), .busy(busy), .done(done), .vended(vended), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // one clock, then sample coin for total and adjacency tracking
  task automatic tick();
    @(posedge clk);
    #1;
    cents += (coin == 2'b01) ? 5 : (coin == 2'b10) ? 10 : 0;
    if (coin != 2'b00 && prev_coin != 2'b00) adj_bad = 1'b1;
    prev_coin = coin;
  endtask
  task automatic accept(input logic [3:0] a, input logic p);
    cents = 0;
    start = 1'b1;
    amount = a;
    prefer_dime = p;
    tick();
    start = 1'b0;
  endtask
  initial begin
    tick();
    chk("rst coin", 8'(coin), 8'd0);
    chk("rst busy", 8'(busy), 8'd0);
    chk("rst done", 8'(done), 8'd0);
    chk("rst vended", 8'(vended), 8'd0);
    chk("rst timeout", 8'(timeout), 8'd0);
    rst = 1'b0;
    tick();
    // three nickels, vend during WAIT_ACK
    accept(4'd3, 1'b0);
    chk("n3 c1", 8'(coin), 8'd1);
    chk("n3 busy", 8'(busy), 8'd1);
    tick(); chk("n3 c2", 8'(coin), 8'd0);
    tick(); chk("n3 c3", 8'(coin), 8'd1);
    tick(); chk("n3 c4", 8'(coin), 8'd0);
    tick(); chk("n3 c5", 8'(coin), 8'd1);
    tick(); chk("n3 c6", 8'(coin), 8'd0);
    tick();
    chk("n3 wait coin", 8'(coin), 8'd0);
    chk("n3 wait busy", 8'(busy), 8'd1);
    chk("n3 wait vended", 8'(vended), 8'd0);
    nw_pa = 1'b1;
    tick();
    nw_pa = 1'b0;
    chk("n3 done", 8'(done), 8'd1);
    chk("n3 vended", 8'(vended), 8'd1);
    chk("n3 timeout", 8'(timeout), 8'd0);
    tick();
    chk("n3 done drop", 8'(done), 8'd0);
    chk("n3 busy drop", 8'(busy), 8'd0);
    chk("n3 vended hold", 8'(vended), 8'd1);
    chk("n3 cents", 8'(cents), 8'd15);
    // dime path, vend seen during final gap
    accept(4'd3, 1'b1);
    chk("d3 c1", 8'(coin), 8'd2);
    chk("d3 vended cleared", 8'(vended), 8'd0);
    tick(); chk("d3 c2", 8'(coin), 8'd0);
    tick(); chk("d3 c3", 8'(coin), 8'd1);
    tick(); chk("d3 c4", 8'(coin), 8'd0);
    nw_pa = 1'b1;
    tick();
    nw_pa = 1'b0;
    chk("d3 wait vended", 8'(vended), 8'd1);
    chk("d3 wait done", 8'(done), 8'd0);
    tick();
    chk("d3 done", 8'(done), 8'd1);
    chk("d3 timeout", 8'(timeout), 8'd0);
    tick();
    chk("d3 cents", 8'(cents), 8'd15);
    chk("d3 busy drop", 8'(busy), 8'd0);
    // early vend after third nickel: fourth still sent, WAIT_ACK exits at once
    accept(4'd4, 1'b0);
    chk("ev c1", 8'(coin), 8'd1);
    tick(); tick(); tick(); tick();
    chk("ev c5", 8'(coin), 8'd1);
    tick();
    chk("ev c6", 8'(coin), 8'd0);
    nw_pa = 1'b1;
    tick();
    nw_pa = 1'b0;
    chk("ev c7 fourth", 8'(coin), 8'd1);
    chk("ev vended early", 8'(vended), 8'd1);
    tick(); chk("ev c8", 8'(coin), 8'd0);
    tick();
    chk("ev wait done", 8'(done), 8'd0);
    chk("ev wait busy", 8'(busy), 8'd1);
    tick();
    chk("ev done", 8'(done), 8'd1);
    chk("ev vended", 8'(vended), 8'd1);
    chk("ev timeout", 8'(timeout), 8'd0);
    tick();
    chk("ev cents", 8'(cents), 8'd20);
    // timeout: single nickel, no vend
    accept(4'd1, 1'b0);
    chk("to c1", 8'(coin), 8'd1);
    tick(); chk("to c2", 8'(coin), 8'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("to wait done", 8'(done), 8'd0);
      chk("to wait busy", 8'(busy), 8'd1);
    end
    tick();
    chk("to done", 8'(done), 8'd1);
    chk("to timeout", 8'(timeout), 8'd1);
    chk("to vended", 8'(vended), 8'd0);
    tick();
    chk("to busy drop", 8'(busy), 8'd0);
    chk("to timeout hold", 8'(timeout), 8'd1);
    chk("to cents", 8'(cents), 8'd5);
    // start with amount 0 is ignored
    accept(4'd0, 1'b1);
    chk("z busy", 8'(busy), 8'd0);
    chk("z coin", 8'(coin), 8'd0);
    chk("z timeout kept", 8'(timeout), 8'd1);
    // second start mid-transaction has no effect
    accept(4'd2, 1'b0);
    chk("ms c1", 8'(coin), 8'd1);
    start = 1'b1;
    amount = 4'd15;
    prefer_dime = 1'b1;
    tick(); chk("ms c2", 8'(coin), 8'd0);
    tick(); chk("ms c3", 8'(coin), 8'd1);
    tick(); chk("ms c4", 8'(coin), 8'd0);
    start = 1'b0;
    nw_pa = 1'b1;
    tick();
    nw_pa = 1'b0;
    tick();
    chk("ms done", 8'(done), 8'd1);
    tick();
    chk("ms busy drop", 8'(busy), 8'd0);
    chk("ms cents", 8'(cents), 8'd10);
    chk("no adjacent coins", 8'(adj_bad), 8'd0);
    // asynchronous reset mid-SEND with start held
    accept(4'd3, 1'b0);
    chk("ar c1", 8'(coin), 8'd1);
    start = 1'b1;
    amount = 4'd5;
    #2 rst = 1'b1;
    #1;
    chk("ar async coin", 8'(coin), 8'd0);
    chk("ar async busy", 8'(busy), 8'd0);
    tick();
    tick();
    start = 1'b0;
    rst = 1'b0;
    tick();
    chk("ar after busy", 8'(busy), 8'd0);
    chk("ar after coin", 8'(coin), 8'd0);
    tick();
    chk("ar idle busy", 8'(busy), 8'd0);
    chk("ar idle coin", 8'(coin), 8'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
